// File: rtl/muldiv_unit_pkg.sv
// Shared widths, funct codes and sign helpers for the EX-stage HI/LO unit.
// Optional iterative multiplier is selected with MULDIV_ITER_MULT_EN.
package muldiv_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;
  localparam int CNT_W   = 6;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [2*DATA_W-1:0] dword_t;
  typedef logic [FUNCT_W-1:0]  funct_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  localparam funct_t FUNCT_MFHI  = 6'h10;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MFLO  = 6'h12;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1a;
  localparam funct_t FUNCT_DIVU  = 6'h1b;

  function automatic data_t neg_if(input data_t v, input logic neg);
    return neg ? data_t'(-v) : v;
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic data_t abs_val(input data_t v);
    return neg_if(v, v[DATA_W-1]);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
interface muldiv_unit_if;

  logic                   flush;
  logic                   en;
  muldiv_unit_pkg::funct_t funct;
  muldiv_unit_pkg::data_t  operand_1;
  muldiv_unit_pkg::data_t  operand_2;
  logic                   stall_request;
  muldiv_unit_pkg::data_t  hilo_read_data;
  muldiv_unit_pkg::data_t  hi_out;
  muldiv_unit_pkg::data_t  lo_out;

  modport master (
    output flush, en, funct, operand_1, operand_2,
    input  stall_request, hilo_read_data, hi_out, lo_out
  );

  modport slave (
    input  flush, en, funct, operand_1, operand_2,
    output stall_request, hilo_read_data, hi_out, lo_out
  );

endinterface

// File: rtl/muldiv_unit_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle; its iteration
// counter also paces the optional shift-add multiplier in the top level.
module div_core
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  abort_i,
  input  logic  start_i,
  input  data_t dividend_i,
  input  data_t divisor_i,
  output logic  busy_o,
  output logic  done_o,
  output data_t quotient_o,
  output data_t remainder_o
);

  logic          busy_q, busy_d;
  cnt_t          cnt_q, cnt_d;
  logic [DATA_W:0] rem_q, rem_d;
  data_t         quo_q, quo_d;
  data_t         dsr_q, dsr_d;

  logic [DATA_W:0] trial, rem_step;
  data_t         quo_step;
  logic          ge, last;

  // quo_q shifts dividend bits out of the top while quotient bits enter below.
  always_comb begin
    trial    = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    ge       = trial >= {1'b0, dsr_q};
    rem_step = ge ? trial - {1'b0, dsr_q} : trial;
    quo_step = {quo_q[DATA_W-2:0], ge};
    last     = busy_q && (cnt_q == cnt_t'(DIV_CYCLES - 1));
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend_i;
      dsr_d  = divisor_i;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + cnt_t'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every register samples pre-edge values.
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = last;
  assign quotient_o  = quo_step;
  assign remainder_o = rem_step[DATA_W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO, MFHI/MFLO read port.
// Define MULDIV_ITER_MULT_EN to replace the single-cycle multiply with a 32-step shift-add.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam data_t ALL_ONES = '1;

  state_e state_q, state_d;
  data_t  hi_q, hi_d, lo_q, lo_d;
  data_t  op1_q, op1_d;
  logic   q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;

  logic   is_div, is_signed_op, is_iter, launch;
  data_t  core_quo, core_rem, div_hi, div_lo;
  logic   core_busy, core_done;

  assign is_div       = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
  assign is_signed_op = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_MULT);

`ifdef MULDIV_ITER_MULT_EN
  logic   is_mul, mul_q, mul_d, p_neg_q, p_neg_d;
  dword_t acc_q, acc_d, mcand_q, mcand_d, acc_step, mul_res;
  data_t  mplier_q, mplier_d;

  assign is_mul   = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
  assign is_iter  = is_div || is_mul;
  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mul_res  = p_neg_q ? -acc_step : acc_step;
`else
  dword_t prod_u, prod_s;

  assign is_iter = is_div;
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_u  = {{DATA_W{1'b0}}, bus.operand_1} * {{DATA_W{1'b0}}, bus.operand_2};
  assign prod_s  = {{DATA_W{bus.operand_1[DATA_W-1]}}, bus.operand_1}
                 * {{DATA_W{bus.operand_2[DATA_W-1]}}, bus.operand_2};
`endif

  assign launch = (state_q == IDLE) && bus.en && !bus.flush && is_iter;

  div_core #(.DIV_CYCLES(DIV_CYCLES)) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .abort_i     (bus.flush),
    .start_i     (launch),
    .dividend_i  (is_signed_op ? abs_val(bus.operand_1) : bus.operand_1),
    .divisor_i   (is_signed_op ? abs_val(bus.operand_2) : bus.operand_2),
    .busy_o      (core_busy),
    .done_o      (core_done),
    .quotient_o  (core_quo),
    .remainder_o (core_rem)
  );

  // Divide-by-zero returns all-ones quotient and the untouched dividend.
  always_comb begin
    if (div0_q) begin
      div_lo = ALL_ONES;
      div_hi = op1_q;
    end else begin
      div_lo = neg_if(core_quo, q_neg_q);
      div_hi = neg_if(core_rem, r_neg_q);
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op1_d   = op1_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
`ifdef MULDIV_ITER_MULT_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mul_d    = mul_q;
    p_neg_d  = p_neg_q;
`endif
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            state_d = BUSY;
            op1_d   = bus.operand_1;
            q_neg_d = is_signed_op && (bus.operand_1[DATA_W-1] ^ bus.operand_2[DATA_W-1]);
            r_neg_d = is_signed_op && bus.operand_1[DATA_W-1];
            div0_d  = (bus.operand_2 == '0);
`ifdef MULDIV_ITER_MULT_EN
            mul_d    = is_mul;
            p_neg_d  = q_neg_d;
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, is_signed_op ? abs_val(bus.operand_1) : bus.operand_1};
            mplier_d = is_signed_op ? abs_val(bus.operand_2) : bus.operand_2;
`endif
          end else if (bus.en) begin
            unique case (bus.funct)
              FUNCT_MTHI:  hi_d = bus.operand_1;
              FUNCT_MTLO:  lo_d = bus.operand_1;
`ifndef MULDIV_ITER_MULT_EN
              FUNCT_MULT:  {hi_d, lo_d} = prod_s;
              FUNCT_MULTU: {hi_d, lo_d} = prod_u;
`endif
              default: ;
            endcase
          end
        end
        BUSY: begin
`ifdef MULDIV_ITER_MULT_EN
          if (mul_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
`endif
          if (core_done) begin
            state_d = DONE;
`ifdef MULDIV_ITER_MULT_EN
            if (mul_q) {hi_d, lo_d} = mul_res;
            else       {hi_d, lo_d} = {div_hi, div_lo};
`else
            {hi_d, lo_d} = {div_hi, div_lo};
`endif
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      op1_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op1_q   <= op1_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
    end
  end

`ifdef MULDIV_ITER_MULT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mul_q    <= 1'b0;
      p_neg_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mul_q    <= mul_d;
      p_neg_q  <= p_neg_d;
    end
  end
`endif

  // The core is busy exactly while the FSM sits in BUSY.
  assign bus.stall_request  = launch || core_busy;
  assign bus.hilo_read_data = (bus.funct == FUNCT_MFHI) ? hi_q :
                              (bus.funct == FUNCT_MFLO) ? lo_q : '0;
  assign bus.hi_out         = hi_q;
  assign bus.lo_out         = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, MFHI/MFLO
// reads checked by a monitor, stall length and HI/LO checked at completion.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    errors = 0;
  int    checks = 0;
  data_t m_hi = '0;
  data_t m_lo = '0;
  data_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  task automatic model_op(input funct_t f, input data_t a, input data_t b);
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      FUNCT_DIV: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      FUNCT_DIVU: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      FUNCT_MULT: begin
        p = longint'(sa * sb);
        {m_hi, m_lo} = p;
      end
      FUNCT_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = p;
      end
      FUNCT_MTHI: m_hi = a;
      FUNCT_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_stall(input funct_t f);
    if (f == FUNCT_DIV || f == FUNCT_DIVU) return 33;
`ifdef MULDIV_ITER_MULT_EN
    if (f == FUNCT_MULT || f == FUNCT_MULTU) return 33;
`endif
    return 0;
  endfunction

  // Issue one instruction, hold it while stalled, as the pipeline would.
  task automatic run_op(input funct_t f, input data_t a, input data_t b);
    int n = 0;
    int es = exp_stall(f);
    if (f == FUNCT_MFHI) exp_q.push_back(m_hi);
    if (f == FUNCT_MFLO) exp_q.push_back(m_lo);
    bus.en = 1'b1; bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
    @(negedge clk);
    if (f == FUNCT_MTHI) check("rd_zero_non_mf", bus.hilo_read_data, 0);
    while (bus.stall_request && n < 200) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("stall_len f=%0h", f), n, es);
    model_op(f, a, b);
    if (es > 0) begin
      check($sformatf("done_hi f=%0h a=%0h b=%0h", f, a, b), bus.hi_out, m_hi);
      check($sformatf("done_lo f=%0h a=%0h b=%0h", f, a, b), bus.lo_out, m_lo);
    end
    @(posedge clk); #1;
    bus.en = 1'b0;
  endtask

  task automatic run_with_reads(input funct_t f, input data_t a, input data_t b);
    run_op(f, a, b);
    run_op(FUNCT_MFHI, '0, '0);
    run_op(FUNCT_MFLO, '0, '0);
  endtask

  // Launch a divide and flush it while it is k stalled cycles in.
  task automatic run_flush(input funct_t f, input data_t a, input data_t b, input int k);
    int n = 0;
    bus.en = 1'b1; bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
    repeat (k) begin
      @(negedge clk);
      if (bus.stall_request) n++;
    end
    check("stall_before_flush", n, k);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.en = 1'b0;
    @(negedge clk);
    check("flush_stall_drop", bus.stall_request, 0);
    check("flush_hi_kept", bus.hi_out, m_hi);
    check("flush_lo_kept", bus.lo_out, m_lo);
    @(posedge clk); #1;
  endtask

  // Monitor: every MFHI/MFLO presented to the unit consumes one expectation.
  always @(negedge clk) begin
    if (!rst && bus.en && (bus.funct == FUNCT_MFHI || bus.funct == FUNCT_MFLO)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hilo_read: got 0x%0h with no expectation queued", bus.hilo_read_data);
      end else begin
        check("hilo_read", bus.hilo_read_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  funct_t rand_ops[6] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO};

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.flush = 1'b0; bus.funct = '0;
    bus.operand_1 = '0; bus.operand_2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_stall", bus.stall_request, 0);
    check("reset_hi", bus.hi_out, 0);
    check("reset_lo", bus.lo_out, 0);
    @(posedge clk); #1;

    run_op(FUNCT_DIV, 32'd7, 32'hFFFF_FFFE);
    run_op(FUNCT_MFLO, '0, '0);
    run_with_reads(FUNCT_DIVU, 32'hFFFF_FFFF, 32'd16);
    run_with_reads(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_with_reads(FUNCT_DIVU, 32'd5, 32'd0);
    run_with_reads(FUNCT_DIV, 32'hFFFF_FFF9, 32'd0);
    run_with_reads(FUNCT_MULT, 32'hFFFF_FFFF, 32'd2);
    run_with_reads(FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2);

    run_op(FUNCT_MTHI, 32'h1111_1111, '0);
    run_op(FUNCT_MTLO, 32'h1111_1111, '0);
    run_flush(FUNCT_DIV, 32'd100, 32'd7, 11);
    run_with_reads(FUNCT_DIVU, 32'd9, 32'd4);

    run_op(FUNCT_MTHI, 32'hDEAD_BEEF, '0);
    run_op(FUNCT_MFHI, '0, '0);
    bus.en = 1'b0; bus.funct = FUNCT_MTLO; bus.operand_1 = 32'h1234_5678;
    @(posedge clk); #1;
    run_op(FUNCT_MFLO, '0, '0);

    for (int i = 0; i < 16; i++) begin
      funct_t f = rand_ops[$urandom_range(5)];
      data_t  a = $urandom;
      data_t  b;
      case ($urandom_range(7))
        0:       b = '0;
        1:       b = data_t'($urandom_range(15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_with_reads(f, a, b);
    end

    // Reset together with flush mid-divide clears HI/LO and the stall.
    run_op(FUNCT_MTHI, 32'hA5A5_A5A5, '0);
    bus.en = 1'b1; bus.funct = FUNCT_DIVU; bus.operand_1 = 32'd1000; bus.operand_2 = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0; bus.en = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check("rst_flush_stall", bus.stall_request, 0);
    check("rst_flush_hi", bus.hi_out, 0);
    check("rst_flush_lo", bus.lo_out, 0);
    @(posedge clk); #1;
    run_with_reads(FUNCT_DIV, 32'hFFFF_FF9C, 32'd7);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- EX-stage HI/LO arithmetic unit.
- Consumes the decoded funct and operand_1/operand_2 produced by instruction decode, after the ID/EX pipeline register.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO and owns the architectural HI/LO registers.
- Supplies HI/LO to MFHI/MFLO and raises a stall request while an iterative divide runs.

Parameters:
- DIV_CYCLES, 32: radix-2 iterations per divide. Must equal the data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- flush  in  1  exception/ERET pipeline flush; aborts any operation in flight
- en  in  1  valid non-bubble instruction present in EX this cycle
- funct  in  `FUNCT_BUS  decoded funct from ID/EX register
- operand_1  in  `DATA_BUS  rs value (dividend/multiplicand, MTHI/MTLO source)
- operand_2  in  `DATA_BUS  rt value (divisor/multiplier)
- stall_request  out  1  holds IF/ID/EX while busy
- hilo_read_data  out  `DATA_BUS  HI for FUNCT_MFHI, LO for FUNCT_MFLO, else 0
- hi_out  out  `DATA_BUS  current HI register
- lo_out  out  `DATA_BUS  current LO register

Behaviour:
- Reset (rst high at posedge): HI=0, LO=0, state=IDLE, counter=0. stall_request is 0 in the cycle after reset.
- States:
  - IDLE→BUSY when en && !flush && funct in {DIV, DIVU} (plus MULT/MULTU under the option).
  - BUSY→DONE after DIV_CYCLES iterations.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on flush.
- stall_request is combinational:
  - 1 in the IDLE launch cycle (en && funct is DIV/DIVU && !flush).
  - 1 throughout BUSY.
  - 0 in DONE and otherwise.
- Divide latency: launch cycle + 32 BUSY cycles stalled (33 total); the DONE cycle releases the stall. HI/LO update at the end of the last BUSY cycle, so they are visible in DONE.
- DONE never relaunches, even though the same instruction is still present with en=1.
- Launch cycle latches:
  - |operand_1| and |operand_2| for DIV; raw operands for DIVU.
  - quotient sign = op1[31]^op2[31]; remainder sign = op1[31].
- Iteration: restoring shift-subtract, one quotient bit per cycle, 33-bit partial remainder.
- Signed result: negate quotient/remainder per the latched signs. Magnitude of 0x80000000 is treated as unsigned 0x80000000. 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero (operand_2==0): still takes full latency; LO=0xFFFFFFFF, HI=operand_1 (raw). Same rule for DIV and DIVU.
- MULT/MULTU (option off): single cycle, no stall. {HI,LO} = 64-bit signed/unsigned product written at the end of the en cycle.
- MTHI/MTLO: write operand_1 at the end of the en cycle, no stall. MFHI/MFLO in the following cycle read the new value; no bypass is needed.
- Writes are suppressed when flush=1 or en=0.
- Flush mid-divide: HI/LO unchanged; stall_request=0 from the next cycle.
- rst and flush in the same cycle: rst wins (identical state outcome; HI/LO cleared).

Optional Feature:
- MULDIV_ITER_MULT_EN defined:
  - MULT/MULTU use 32-cycle shift-add sharing the BUSY counter. Same stall/latency profile as divide (33 stalled cycles + DONE).
  - Signed MULT negates the product when the signs differ.
  - No `*` operator is synthesized.
- Not defined: single-cycle `*` multiply as above.

Decomposition:
- Existing shared headers: funct codes (FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO) in funct.v; widths in bus.v.
- Add to bus.v: `DOUBLE_DATA_BUS and a 6-bit iteration-counter width.
- State encodings as localparams inside the module.
- One sub-module, div_core: the unsigned iterative datapath (start, dividend, divisor, busy, done, quotient, remainder). It is reused for the iterative multiplier control only by counter sharing.

Test Plan:
- Reset, then DIV 7 / -2 (operand_2=0xFFFFFFFE):
  - stall_request high exactly 33 cycles.
  - DONE: LO=0xFFFFFFFD, HI=0x00000001.
  - Next cycle MFLO → hilo_read_data=0xFFFFFFFD.
- DIVU 0xFFFFFFFF / 16 → LO=0x0FFFFFFF, HI=0x0000000F. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → after full latency LO=0xFFFFFFFF, HI=0x00000005. No hang, stall drops at DONE.
- MULT 0xFFFFFFFF×2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
  - Option off: zero stall.
  - Option on: 33-cycle stall, identical results.
- HI=LO=0x11111111 preset; launch DIV; assert flush on BUSY cycle 10 → stall low next cycle, HI/LO still 0x11111111. A new DIVU 9/4 then completes with LO=2, HI=1.
- Back-to-back MTHI 0xDEADBEEF then MFHI → hilo_read_data=0xDEADBEEF. MTLO with en=0 → LO unchanged.
